// File: rtl/qaccum_pkg.sv
// Shared definitions for the sign-magnitude Q-format accumulator.
// Holds the state encoding and the default fixed-point format.
package qaccum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int unsigned DEF_Q = 23;
    localparam int unsigned DEF_N = 32;

endpackage

// File: rtl/qaccum_qadd.sv
// Combinational sign-magnitude adder. The magnitude wraps on carry-out;
// saturation is the caller's job. A zero result always carries sign 0.
module qadd
    import qaccum_pkg::*;
#(
    parameter int unsigned Q = DEF_Q,
    parameter int unsigned N = DEF_N
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_c
);

    localparam int unsigned IW = N - 1 - Q;

    logic [N-2:0]  a_mag;
    logic [N-2:0]  b_mag;
    logic [N-2:0]  mag;
    logic          sgn;
    logic [Q:0]    frac_sum;
    logic [IW-1:0] int_sum;

    assign a_mag = i_a[N-2:0];
    assign b_mag = i_b[N-2:0];

    always_comb begin
        // fraction and integer fields added separately, carry rippling between them
        frac_sum = {1'b0, a_mag[Q-1:0]} + {1'b0, b_mag[Q-1:0]};
        int_sum  = a_mag[N-2:Q] + b_mag[N-2:Q] + {{(IW-1){1'b0}}, frac_sum[Q]};
        mag      = '0;
        sgn      = 1'b0;
        if (i_a[N-1] == i_b[N-1]) begin
            mag = {int_sum, frac_sum[Q-1:0]};
            sgn = i_a[N-1];
        end else if (a_mag >= b_mag) begin
            mag = a_mag - b_mag;
            sgn = i_a[N-1];
        end else begin
            mag = b_mag - a_mag;
            sgn = i_b[N-1];
        end
        o_c = {sgn && (mag != '0), mag};
    end

endmodule

// File: rtl/qaccum.sv
// Saturating sign-magnitude accumulator with valid/ready sample input and
// a held result that is handed off downstream on valid/ready.
module qaccum
    import qaccum_pkg::*;
#(
    parameter int unsigned Q     = DEF_Q,
    parameter int unsigned N     = DEF_N,
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [N-1:0]     i_data,
    input  logic             i_last,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [N-1:0]     o_sum,
    output logic [CNT_W-1:0] o_count,
    output logic             o_overflow
);

    state_e           state_q, state_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;

    logic [N-1:0]     add_c;
    logic             wrap;
    logic [N-1:0]     sat_sum;

    qadd #(
        .Q (Q),
        .N (N)
    ) u_qadd (
        .i_a (acc_q),
        .i_b (i_data),
        .o_c (add_c)
    );

    // with equal signs the magnitude sum wrapped iff it came out below the accumulator
    always_comb begin
        wrap    = (acc_q[N-1] == i_data[N-1]) && (add_c[N-2:0] < acc_q[N-2:0]);
        sat_sum = wrap ? {acc_q[N-1], {(N-1){1'b1}}} : add_c;
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (i_clear) begin
            state_d = ST_IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_ACCUM: begin
                    if (i_valid) begin
                        acc_d   = sat_sum;
                        ovf_d   = ovf_q | wrap;
                        count_d = (count_q == '1) ? count_q : count_q + CNT_W'(1);
                        state_d = i_last ? ST_DONE : ST_ACCUM;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state_d = ST_IDLE;
                        acc_d   = '0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    acc_d   = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign o_ready    = (state_q != ST_DONE);
    assign o_valid    = (state_q == ST_DONE);
    assign o_sum      = acc_q;
    assign o_count    = count_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_qaccum.sv
// Self-checking bench for qaccum (Q=23, N=32): an integer-domain clamping
// model feeds a scoreboard of expected results, popped when o_valid rises.
module tb_qaccum;

    localparam int unsigned N     = 32;
    localparam int unsigned CNT_W = 16;
    localparam longint      MAXV  = (64'sd1 <<< (N - 1)) - 1;

    typedef struct packed {
        logic [N-1:0]     sum;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
    } result_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             valid = 1'b0;
    logic             ready_out;
    logic [N-1:0]     data = '0;
    logic             last = 1'b0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [N-1:0]     sum;
    logic [CNT_W-1:0] count;
    logic             ovf;

    int unsigned errors = 0;
    int unsigned checks = 0;

    result_t          sb[$];
    longint           m_val = 0;
    logic [CNT_W-1:0] m_cnt = '0;
    logic             m_ovf = 1'b0;

    qaccum #(
        .Q     (23),
        .N     (N),
        .CNT_W (CNT_W)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_clear    (clear),
        .i_valid    (valid),
        .o_ready    (ready_out),
        .i_data     (data),
        .i_last     (last),
        .o_valid    (res_valid),
        .i_ready    (res_ready),
        .o_sum      (sum),
        .o_count    (count),
        .o_overflow (ovf)
    );

    always #5 clk = ~clk;

    function automatic longint to_int(input logic [N-1:0] d);
        longint mag;
        mag = longint'(d[N-2:0]);
        return d[N-1] ? -mag : mag;
    endfunction

    function automatic logic [N-1:0] from_int(input longint v);
        logic [63:0] a;
        a = (v < 0) ? 64'(-v) : 64'(v);
        return {(v < 0), a[N-2:0]};
    endfunction

    task automatic model_clear();
        m_val = 0;
        m_cnt = '0;
        m_ovf = 1'b0;
    endtask

    // Called at a falling edge; presents one sample for exactly one rising edge.
    task automatic send(input logic [N-1:0] d, input logic l);
        valid = 1'b1;
        data  = d;
        last  = l;
        @(negedge clk);
        valid = 1'b0;
        last  = 1'b0;
        m_val = m_val + to_int(d);
        if (m_val > MAXV) begin
            m_val = MAXV;
            m_ovf = 1'b1;
        end else if (m_val < -MAXV) begin
            m_val = -MAXV;
            m_ovf = 1'b1;
        end
        if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
        if (l) sb.push_back('{sum: from_int(m_val), cnt: m_cnt, ovf: m_ovf});
    endtask

    // Waits for a held result, compares it to the scoreboard, then hands it off.
    task automatic take_result(input string name, input bit by_clear);
        int unsigned n = 0;
        result_t exp;
        while (res_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (res_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: o_valid=%b required 1", name, res_valid);
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_unexpected: o_valid=1 required no result", name);
        end else begin
            exp = sb.pop_front();
            checks++;
            if (sum !== exp.sum) begin
                errors++;
                $display("FAIL %s_sum: got %h required %h", name, sum, exp.sum);
            end
            checks++;
            if (count !== exp.cnt || ovf !== exp.ovf || ready_out !== 1'b0) begin
                errors++;
                $display("FAIL %s_flags: count=%0d ovf=%b ready=%b required %0d %b 0",
                         name, count, ovf, ready_out, exp.cnt, exp.ovf);
            end
        end
        if (by_clear) clear = 1'b1;
        else res_ready = 1'b1;
        @(negedge clk);
        clear     = 1'b0;
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || sum !== '0 || count !== '0 || ovf !== 1'b0 || ready_out !== 1'b1) begin
            errors++;
            $display("FAIL %s_handoff: valid=%b sum=%h count=%0d ovf=%b ready=%b required 0 0 0 0 1",
                     name, res_valid, sum, count, ovf, ready_out);
        end
        model_clear();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (res_valid !== 1'b0 || sum !== '0 || count !== '0 || ovf !== 1'b0 || ready_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: valid=%b sum=%h count=%0d ovf=%b ready=%b required 0 0 0 0 1",
                     res_valid, sum, count, ovf, ready_out);
        end
        model_clear();
    endtask

    task automatic test_basic();
        send(32'h0080_0000, 1'b0);
        checks++;
        if (sum !== 32'h0080_0000 || count !== 16'd1) begin
            errors++;
            $display("FAIL basic_latency: sum=%h count=%0d required 00800000 1", sum, count);
        end
        send(32'h00C0_0000, 1'b1);
        checks++;
        if (sum !== 32'h0140_0000) begin
            errors++;
            $display("FAIL basic_const: sum=%h required 01400000", sum);
        end
        take_result("basic", 1'b0);
    endtask

    task automatic test_signs();
        send(32'h0080_0000, 1'b0);
        send(32'h8080_0000, 1'b1);
        take_result("cancel_zero", 1'b0);
        send(32'h8080_0000, 1'b0);
        send(32'h0040_0000, 1'b1);
        checks++;
        if (sum !== 32'h8040_0000) begin
            errors++;
            $display("FAIL neg_half_const: sum=%h required 80400000", sum);
        end
        take_result("neg_half", 1'b0);
        send(32'h8000_0000, 1'b1);
        take_result("neg_zero_in", 1'b0);
    endtask

    task automatic test_saturation();
        send(32'h7FFF_FFFF, 1'b0);
        send(32'h0000_0001, 1'b0);
        checks++;
        if (sum !== 32'h7FFF_FFFF || ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat_pos: sum=%h ovf=%b required 7fffffff 1", sum, ovf);
        end
        send(32'h8000_0005, 1'b1);
        checks++;
        if (sum !== 32'h7FFF_FFFA || ovf !== 1'b1) begin
            errors++;
            $display("FAIL sat_sticky: sum=%h ovf=%b required 7ffffffa 1", sum, ovf);
        end
        take_result("sat", 1'b0);
        send(32'hC000_0000, 1'b0);
        send(32'hC000_0001, 1'b1);
        take_result("sat_neg", 1'b0);
    endtask

    task automatic test_hold();
        logic [N-1:0] held;
        send(32'h0123_4567, 1'b0);
        send(32'h0000_1111, 1'b1);
        held = from_int(m_val);
        for (int i = 0; i < 5; i++) begin
            valid = 1'b1;
            data  = 32'h0000_0100 + 32'(i);
            last  = i[0];
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || ready_out !== 1'b0 || sum !== held || count !== 16'd2) begin
                errors++;
                $display("FAIL hold_%0d: valid=%b ready=%b sum=%h count=%0d required 1 0 %h 2",
                         i, res_valid, ready_out, sum, count, held);
            end
        end
        valid = 1'b0;
        last  = 1'b0;
        take_result("hold", 1'b0);
    endtask

    task automatic test_reset_mid();
        send(32'h0100_0000, 1'b0);
        send(32'h0200_0000, 1'b0);
        rst_n = 1'b0;
        clear = 1'b1;
        valid = 1'b1;
        data  = 32'h0300_0000;
        @(negedge clk);
        rst_n = 1'b1;
        clear = 1'b0;
        valid = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || sum !== '0 || count !== '0 || ovf !== 1'b0 || ready_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: valid=%b sum=%h count=%0d ovf=%b ready=%b required 0 0 0 0 1",
                     res_valid, sum, count, ovf, ready_out);
        end
        model_clear();
        send(32'h0300_0000, 1'b0);
        send(32'h0400_0000, 1'b1);
        take_result("after_reset", 1'b0);
    endtask

    task automatic test_clear();
        send(32'h7FFF_0000, 1'b0);
        send(32'h7FFF_0000, 1'b0);
        clear = 1'b1;
        valid = 1'b1;
        last  = 1'b1;
        data  = 32'h0000_0040;
        @(negedge clk);
        clear = 1'b0;
        valid = 1'b0;
        last  = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || sum !== '0 || count !== '0 || ovf !== 1'b0 || ready_out !== 1'b1) begin
            errors++;
            $display("FAIL clear_accept: valid=%b sum=%h count=%0d ovf=%b ready=%b required 0 0 0 0 1",
                     res_valid, sum, count, ovf, ready_out);
        end
        model_clear();
        send(32'h0000_0040, 1'b1);
        take_result("clear_done", 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 6; s++) begin
            int unsigned len;
            len = $urandom_range(1, 6);
            for (int unsigned k = 0; k < len; k++)
                send($urandom() & ((s < 3) ? 32'h80FF_FFFF : 32'hFFFF_FFFF), k == len - 1);
            take_result($sformatf("b2b_%0d", s), 1'b0);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_signs();
        test_saturation();
        test_hold();
        test_reset_mid();
        test_clear();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/qaccum.md
QACCUM -- requirements
Module: qaccum

Interface
REQ-001 Parameter Q, default 23, number of fraction bits.
REQ-002 Parameter N, default 32, total word width; bit N-1 is sign, bits N-2:0 are magnitude (sign-magnitude Q format).
REQ-003 Parameter CNT_W, default 16, width of sample counter.
REQ-004 i_clk  in  1  single clock; all state changes on rising edge.
REQ-005 i_rst_n  in  1  reset, synchronous, active-low.
REQ-006 i_clear  in  1  synchronous clear of accumulation.
REQ-007 i_valid  in  1  input sample valid.
REQ-008 o_ready  out  1  block can accept a sample.
REQ-009 i_data  in  N  input sample, sign-magnitude Q format.
REQ-010 i_last  in  1  marks final sample of a sequence; qualified by i_valid && o_ready.
REQ-011 o_valid  out  1  o_sum is a completed result.
REQ-012 i_ready  in  1  downstream accepts result.
REQ-013 o_sum  out  N  accumulator value, sign-magnitude Q format.
REQ-014 o_count  out  CNT_W  samples accepted in current sequence.
REQ-015 o_overflow  out  1  sticky saturation flag for current sequence.

Function
REQ-016 States: IDLE (accumulator zero, awaiting first sample), ACCUM (sequence in progress), DONE (result held).
REQ-017 o_ready = 1 in IDLE and ACCUM, 0 in DONE.
REQ-018 Accept = i_valid && o_ready; on accept, accumulator <= sat(accumulator + i_data) at that edge; o_sum shows new value next cycle (1-cycle latency).
REQ-019 Accept without i_last: IDLE->ACCUM, ACCUM->ACCUM; accept with i_last: IDLE/ACCUM->DONE.
REQ-020 o_valid = 1 exactly while in DONE; o_sum, o_count, o_overflow held stable in DONE.
REQ-021 DONE with i_ready = 1: at that edge -> IDLE, accumulator, o_count, o_overflow cleared; DONE with i_ready = 0: remain, hold outputs.
REQ-022 Equal signs: magnitudes added; if sum >= 2^(N-1), magnitude saturates to all ones, sign kept, o_overflow set.
REQ-023 Different signs: larger magnitude minus smaller, sign of larger magnitude; no overflow possible.
REQ-024 Zero result always has sign 0 (no negative zero on o_sum); input -0 treated as +0.
REQ-025 o_overflow sticky until clear, reset, or result handoff.
REQ-026 o_count increments by 1 per accept, saturates at 2^CNT_W-1 (no wrap).
REQ-027 i_clear = 1: at that edge -> IDLE, accumulator/o_count/o_overflow zero, sample presented that cycle discarded; overrides accept and DONE handoff.
REQ-028 i_clear in DONE discards held result; o_valid falls next cycle.
REQ-029 i_last with i_valid = 0 ignored.

Reset
REQ-030 i_rst_n = 0 at rising edge: state IDLE, o_sum = 0, o_count = 0, o_overflow = 0, o_valid = 0; o_ready = 1 from the first cycle after reset.
REQ-031 Reset takes priority over i_clear and all handshakes, including mid-sequence and in DONE.

Structure
REQ-032 Combinational sign-magnitude add is the existing qadd sub-module (parameters Q, N), instantiated once; saturation and overflow detection in qaccum around it.
REQ-033 Shared package holds state encoding (IDLE/ACCUM/DONE) and default Q/N constants; no other typedefs.
REQ-034 Single always block for registers, synchronous reset only, no latches.

Verification (Q=23, N=32)
REQ-035 Accept 0x00800000 (1.0), then 0x00C00000 (1.5) with i_last, i_ready=1 -> o_valid one cycle, o_sum = 0x01400000, o_count = 2, o_overflow = 0.
REQ-036 0x00800000 then 0x80800000 (-1.0) last -> o_sum = 0x00000000 (sign 0); then 0x80800000 then 0x00400000 last -> o_sum = 0x80400000.
REQ-037 0x7FFFFFFF then 0x00000001 last -> o_sum = 0x7FFFFFFF, o_overflow = 1; then 0x80000005 last -> o_sum = 0x7FFFFFFA, o_overflow still 1.
REQ-038 Hold i_ready = 0 for 5 cycles in DONE -> o_valid, o_sum stable, o_ready = 0, offered samples not accepted; i_ready = 1 -> IDLE next cycle, o_count = 0.
REQ-039 Reset asserted after 2 of 4 samples, and separately i_clear with i_valid=1 -> all outputs zero next cycle, o_ready = 1, next sequence sums from zero.
